fir_bank: RTL and testbench
===========================

# fir_bank

Parametrised multi-bank FIR engine that succeeds the fixed three-filter sampling block in the oscilloscope filter IP. It keeps an internal sample history and a run-time loadable coefficient memory holding `NBANK` filter sets. Each accepted sample runs one multiply-accumulate pass over `TAPS` coefficients, followed by a rounded, saturated result and a `done` pulse. It sits between the XADC sample path and the display/capture logic and replaces the per-filter HLS cores with one shared MAC.

## Interface
- `TAPS`, 23: filter length and sample history depth (≥2).
- `DW`, 16: sample and result width, signed two's complement.
- `CW`, 32: coefficient width, signed.
- `FRAC`, 16: fractional bits of the coefficients (0 < `FRAC` < `CW`).
- `NBANK`, 4: number of coefficient banks (≥1).
- `BW`, clog2(`NBANK`) (min 1): bank index width.
- `AW`, clog2(`TAPS`): tap index width.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: accept `sample_in`; honoured only while `busy`=0.
- `sample_in` in `DW`: new sample.
- `bank_sel` in `BW`: coefficient bank used for this pass; latched at `start`.
- `bypass` in 1: pass sample through unfiltered; latched at `start`.
- `flush` in 1: zero the sample history; honoured only while idle.
- `coef_we` in 1: coefficient write strobe.
- `coef_bank` in `BW`: write bank.
- `coef_addr` in `AW`: write tap index.
- `coef_data` in `CW`: write data.
- `busy` out 1: high from the cycle after an accepted `start` until `done` deasserts.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle on.
- `result` out `DW`: last filter output; held until the next `done`.
- `coef_err` out 1: one-cycle pulse when a write is rejected.

## Operation
- Reset values:
  - `busy`=0, `done`=0, `result`=0, `coef_err`=0.
  - Whole history = 0, all coefficients = 0, write pointer `wp`=0.
- States:
  - IDLE: `start` → write `sample_in` to `hist[wp]`. Latch `bank_sel` and `bypass`. Clear the accumulator, set `k`=0. Go to MAC (or OUT if bypass). `wp` advances modulo `TAPS`, wrapping from `TAPS-1` to 0.
  - MAC: each cycle, `acc += hist[(wp_new - 1 - k) mod TAPS] * coef[bank][k]`, then `k++`. After `k = TAPS-1` go to OUT. Tap 0 always multiplies the newest sample.
  - OUT: register `result`, assert `done`, return to IDLE.
- Arithmetic:
  - Products are full `DW+CW` bits.
  - Accumulator is `DW+CW+clog2(TAPS)` bits; it cannot overflow.
  - Output = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
  - The output is then saturated to [-2^(DW-1), 2^(DW-1)-1].
- Bypass: `result` = latched sample, unmodified. The history is still updated.
- Coefficient writes:
  - Accepted in any state except when `busy`=1 and `coef_bank` equals the latched bank. That case is ignored and pulses `coef_err` the next cycle.
  - Writes to other banks are accepted while busy.
  - `coef_addr` ≥ `TAPS` is ignored and pulses `coef_err`.
- `start` while busy: ignored; no error flag.
- `flush`:
  - While idle, zeroes the history and `wp` in one cycle.
  - `flush` with `start` in the same IDLE cycle: flush wins and `start` is dropped.
  - While busy, `flush` is ignored.
- `bank_sel` ≥ `NBANK` at `start`: the bank is treated as all-zero coefficients, giving `result`=0.
- `rst` asserted mid-pass: the pass is aborted immediately, all state returns to reset values, and no `done` is produced.

## Timing
- `start` sampled at edge E0 → `busy`=1 after E0.
  - MAC on edges E1..E`TAPS`.
  - OUT state entered after E`TAPS`; `done`=1 and `result` valid after edge E`TAPS`+1.
  - `busy`=0 after edge E`TAPS`+2.
  - Throughput: one sample per `TAPS`+2 cycles.
- Bypass: `done`=1 after E1, `busy`=0 after E2.
- A coefficient write on edge E is visible to any pass whose MAC reads that tap after E.
- `coef_err` is high for the single cycle after the rejected write edge.

## Test plan
- **Impulse response** (`TAPS`=4, `FRAC`=16): load bank 0 with 0x00010000, 0x00008000, 0x00004000, 0. Feed 1000, 0, 0, 0 → `result` 1000, 500, 250, 0. Each `done` arrives exactly 5 cycles after its `start`.
- **Saturation and wrap-around**: bank 1 all 0x00010000. Feed 30000 ×4 → results 30000, 32767, 32767, 32767. Then feed -30000 ×6 → the final result is -32768.
- **Bypass and bank isolation**: `bypass`=1, sample 0x8001 → `result`=0x8001 with `done` 1 cycle after `start`. A following filtered pass on bank 0 includes 0x8001 in its history.
- **Write arbitration**:
  - During a bank 0 pass, write bank 0 tap 2 → `coef_err` pulses and the tap is unchanged.
  - Write bank 2 during the same pass → accepted.
  - `coef_addr`=5 with `TAPS`=4 → `coef_err`.
- **Start/flush conflicts**:
  - `start` pulsed while `busy` → ignored, single `done`.
  - `flush`+`start` in the same idle cycle → no pass occurs and the history reads zero, so the next impulse pass reproduces test 1 exactly.
- **Reset mid-operation**: assert `rst` at E2 of a pass → `busy`, `done`, `result`, `coef_err` = 0 immediately. Coefficients are cleared, so the next pass returns 0.

Source files
------------

// File: rtl/fir_bank.sv
// Multi-bank FIR engine: one shared MAC steps through TAPS coefficients per accepted sample; done TAPS+1 cycles after start (bypass: 1).
// No backpressure: start is dropped while busy; coefficient writes aimed at the bank in use are rejected and flagged on coef_err.
module fir_bank #(
  parameter int TAPS  = 23,
  parameter int DW    = 16,
  parameter int CW    = 32,
  parameter int FRAC  = 16,
  parameter int NBANK = 4,
  parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
  parameter int AW    = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] sample_in,
  input  logic [BW-1:0] bank_sel,
  input  logic          bypass,
  input  logic          flush,
  input  logic          coef_we,
  input  logic [BW-1:0] coef_bank,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          coef_err
);

  localparam int PW   = DW + CW;
  localparam int ACCW = PW + $clog2(TAPS);
  localparam int RW   = ACCW + 1;
  localparam logic [RW-1:0] RND  = RW'(1) << (FRAC - 1);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t state, state_nxt;

  logic [TAPS-1:0][DW-1:0]            hist;
  logic [NBANK-1:0][TAPS-1:0][CW-1:0] coef;
  logic [AW-1:0]          wp, rp, k;
  logic [BW-1:0]          bank_q;
  logic                   bypass_q;
  logic [DW-1:0]          sample_q;
  logic signed [ACCW-1:0] acc;
  logic [CW-1:0]          coef_rd;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   acc_rnd, acc_shr;
  logic [DW-1:0]          sat;
  logic                   accept, do_flush, wr_bad, wr_ok;

  // busy spans the done cycle too, so a back-to-back start is held off one cycle
  assign busy     = (state != S_IDLE) | done;
  assign do_flush = flush & ~busy;
  assign accept   = start & ~busy & ~flush;
  assign wr_bad   = coef_we & ((int'(coef_addr) >= TAPS) | (busy & (coef_bank == bank_q)));
  assign wr_ok    = coef_we & ~wr_bad & (int'(coef_bank) < NBANK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = bypass ? S_OUT : S_MAC;
      S_MAC:   if (k == LAST) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // an out-of-range bank reads as all-zero coefficients
  always_comb begin
    coef_rd = '0;
    if (int'(bank_q) < NBANK) coef_rd = coef[bank_q][k];
  end

  always_comb prod = $signed(hist[rp]) * $signed(coef_rd);

  always_comb begin
    acc_rnd = $signed({acc[ACCW-1], acc}) + $signed(RND);
    acc_shr = acc_rnd >>> FRAC;
    sat     = acc_shr[DW-1:0];
    if (!((&acc_shr[RW-1:DW-1]) | ~(|acc_shr[RW-1:DW-1])))
      sat = acc_shr[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  // rp starts at the slot just written and walks backwards, so tap 0 sees the newest sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= '0;
      wp       <= '0;
      rp       <= '0;
      k        <= '0;
      bank_q   <= '0;
      bypass_q <= 1'b0;
      sample_q <= '0;
      acc      <= '0;
      done     <= 1'b0;
      result   <= '0;
      coef_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      coef_err <= wr_bad;
      case (state)
        S_IDLE: begin
          if (do_flush) begin
            hist <= '0;
            wp   <= '0;
          end else if (accept) begin
            hist[wp] <= sample_in;
            wp       <= (wp == LAST) ? '0 : wp + AW'(1);
            rp       <= wp;
            k        <= '0;
            acc      <= '0;
            bank_q   <= bank_sel;
            bypass_q <= bypass;
            sample_q <= sample_in;
          end
        end
        S_MAC: begin
          acc <= acc + {{(ACCW-PW){prod[PW-1]}}, prod};
          k   <= k + AW'(1);
          rp  <= (rp == '0) ? LAST : rp - AW'(1);
        end
        S_OUT: begin
          done   <= 1'b1;
          result <= bypass_q ? sample_q : sat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        coef <= '0;
    else if (wr_ok) coef[coef_bank][coef_addr] <= coef_data;
  end

endmodule

// File: tb/tb_fir_bank.sv
// Randomised scoreboard bench for fir_bank against a queue-based reference filter model.
module tb_fir_bank;

  localparam int TAPS = 5, DW = 16, CW = 32, FRAC = 16, NBANK = 3, BW = 2, AW = 3;

  logic clk = 1'b0;
  logic rst, start, bypass, flush, coef_we;
  logic [DW-1:0] sample_in;
  logic [BW-1:0] bank_sel, coef_bank;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic busy, done, coef_err;
  logic [DW-1:0] result;

  always #5 clk = ~clk;

  fir_bank #(.TAPS(TAPS), .DW(DW), .CW(CW), .FRAC(FRAC), .NBANK(NBANK)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in), .bank_sel(bank_sel),
    .bypass(bypass), .flush(flush), .coef_we(coef_we), .coef_bank(coef_bank),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy), .done(done),
    .result(result), .coef_err(coef_err)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [15:0] res; int at; } exp_t;
  exp_t sb[$];
  int   err_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: newest-first sample list and a plain coefficient table
  shortint mh[$];
  int      mcoef [NBANK][TAPS];

  function automatic void model_reset();
    mh.delete();
    for (int i = 0; i < TAPS; i++) mh.push_back(0);
    for (int b = 0; b < NBANK; b++)
      for (int t = 0; t < TAPS; t++) mcoef[b][t] = 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < TAPS; i++) mh[i] = 0;
  endfunction

  function automatic shortint model_pass(int bank, bit byp, shortint s);
    longint acc;
    mh.push_front(s);
    void'(mh.pop_back());
    if (byp) return s;
    acc = 0;
    if (bank < NBANK)
      for (int t = 0; t < TAPS; t++) acc += longint'(mh[t]) * longint'(mcoef[bank][t]);
    acc = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    if (acc > 32767)  return 16'sh7fff;
    if (acc < -32768) return 16'sh8000;
    return shortint'(acc);
  endfunction

  int t0 = 0, pass_bank = 0;
  bit in_pass = 0, pass_byp = 0;

  // busy-fall recorder: cycle index of the edge after which busy dropped
  bit prev_busy = 0;
  int fall_cyc = -1;
  always @(posedge clk) begin
    #1;
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
  end

  // Monitor: pops the scoreboard on every done, and checks coef_err pulses
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ee;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", cyc, e.at);
        end
      end
      ee = (err_q.size() > 0) && (err_q[0] == cyc);
      if (ee) void'(err_q.pop_front());
      if (ee || coef_err) chk("coef_err", coef_err, ee);
    end
  end

  // All stimulus tasks are entered and left on a falling edge
  task automatic issue(input int bank, input bit byp, input shortint s);
    t0        = cyc;
    start     = 1'b1;
    sample_in = s;
    bank_sel  = BW'(bank);
    bypass    = byp;
    sb.push_back('{res: model_pass(bank, byp, s), at: cyc + (byp ? 2 : TAPS + 2)});
    in_pass   = 1'b1;
    pass_bank = bank;
    pass_byp  = byp;
    @(negedge clk);
    start  = 1'b0;
    bypass = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * TAPS) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_cycle", fall_cyc, t0 + (pass_byp ? 3 : TAPS + 3));
    in_pass = 1'b0;
  endtask

  task automatic cwrite(input int bank, input int addr, input int data);
    bit busy_now, bad;
    busy_now = in_pass && (cyc >= t0 + 1) && (cyc <= t0 + (pass_byp ? 2 : TAPS + 2));
    bad      = (addr >= TAPS) || (busy_now && bank == pass_bank);
    if (bad) err_q.push_back(cyc + 1);
    else if (bank < NBANK) mcoef[bank][addr] = data;
    coef_we   = 1'b1;
    coef_bank = BW'(bank);
    coef_addr = AW'(addr);
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  function automatic int rand_coef();
    if ($urandom_range(0, 1) == 1) return int'($urandom);
    return int'($urandom_range(0, 32'h40000)) - 32'h20000;
  endfunction

  task automatic impulse_seq();
    int imp[4];
    imp = '{1000, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, shortint'(imp[i]));
      wait_idle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bypass = 1'b0; flush = 1'b0; coef_we = 1'b0;
    sample_in = '0; bank_sel = '0; coef_bank = '0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_coef_err", coef_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // impulse response on bank 0
    cwrite(0, 0, 32'h00010000);
    cwrite(0, 1, 32'h00008000);
    cwrite(0, 2, 32'h00004000);
    cwrite(0, 3, 0);
    impulse_seq();

    // saturation and history wrap on bank 1
    for (int t = 0; t < TAPS; t++) cwrite(1, t, 32'h00010000);
    repeat (4) begin issue(1, 0, 30000);  wait_idle(); end
    repeat (6) begin issue(1, 0, -30000); wait_idle(); end

    // bypass, then a filtered pass that sees the bypassed sample
    issue(0, 1, shortint'(16'h8001)); wait_idle();
    issue(0, 0, 0);                   wait_idle();

    // write arbitration during a bank 0 pass, plus a start while busy
    issue(0, 0, 1234);
    cwrite(0, 2, 32'h7777);
    cwrite(2, 1, 32'h20000);
    cwrite(2, 5, 1);
    cwrite(0, 7, 1);
    start = 1'b1; sample_in = 16'd999;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    issue(2, 0, 100); wait_idle();
    issue(0, 0, 0);   wait_idle();

    // flush and start together: flush wins, no pass
    flush = 1'b1; start = 1'b1; sample_in = 16'd555;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    model_flush();
    chk("flush_start_no_pass", busy, 0);
    impulse_seq();

    // non-existent bank reads as zero
    issue(3, 0, 20000); wait_idle();

    // randomised traffic
    for (int i = 0; i < 200; i++) begin
      int  bank;
      bit  byp;
      if ($urandom_range(0, 3) == 0)
        cwrite($urandom_range(0, 3), $urandom_range(0, 7), rand_coef());
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
      end
      bank = $urandom_range(0, 3);
      byp  = ($urandom_range(0, 5) == 0);
      issue(bank, byp, shortint'($urandom));
      if ($urandom_range(0, 1) == 1)
        cwrite($urandom_range(0, 3), $urandom_range(0, 7), rand_coef());
      if (!byp && $urandom_range(0, 2) == 0) begin
        start = 1'b1; sample_in = DW'($urandom); flush = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
      end
      wait_idle();
    end

    // reset in the middle of a pass
    issue(0, 1, shortint'(16'h1234)); wait_idle();
    issue(0, 0, 77);
    @(negedge clk);
    coef_we = 1'b1; coef_bank = 2'd1; coef_addr = 3'd7; coef_data = '0;
    @(posedge clk);
    #1;
    chk("err_before_rst", coef_err, 1);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    coef_we = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_coef_err", coef_err, 0);
    sb.delete();
    err_q.delete();
    model_reset();
    in_pass = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 0, shortint'($urandom)); wait_idle();
    issue(1, 0, shortint'($urandom)); wait_idle();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("coef_err_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
